// File: rtl/key_debouncer_if.sv
// key_debouncer_if: raw active-low keys in; debounced level and press/release pulses out
interface key_debouncer_if #(
    parameter int N_KEYS = 3
);
    logic [N_KEYS-1:0] key;
    logic [N_KEYS-1:0] key_db;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] rel;
    modport master (output key, input key_db, press, rel);
    modport slave (input key, output key_db, press, rel);
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: per-channel 2-FF sync, stability filter and press/release pulses; define KEY_DEBOUNCER_REPEAT_EN for auto-repeat
module key_debouncer #(
    parameter int N_KEYS = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input logic clk,
    input logic rst,
    key_debouncer_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
`ifdef KEY_DEBOUNCER_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + REPEAT_PERIOD);
`endif
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("key_debouncer: illegal parameter value");
    end
    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        logic s1, s2;
        state_t state, state_nx;
        logic [CW-1:0] cnt, cnt_nx;
        logic press_q, press_nx, rel_q, rel_nx, db_q;
        logic done;
`ifdef KEY_DEBOUNCER_REPEAT_EN
        logic [RW-1:0] rcnt, rcnt_nx;
`endif
        assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
        assign bus.key_db[i] = db_q;
        assign bus.press[i] = press_q;
        assign bus.rel[i] = rel_q;
        // two-stage synchronizer, parked at "released" in reset
        always_ff @(posedge clk) begin
            if (rst) {s1, s2} <= 2'b11;
            else {s1, s2} <= {bus.key[i], s1};
        end
        // state, counters and registered outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                cnt <= '0;
                press_q <= 1'b0;
                rel_q <= 1'b0;
                db_q <= 1'b1;
`ifdef KEY_DEBOUNCER_REPEAT_EN
                rcnt <= '0;
`endif
            end else begin
                state <= state_nx;
                cnt <= cnt_nx;
                press_q <= press_nx;
                rel_q <= rel_nx;
                db_q <= state_nx == IDLE || state_nx == PRESS_WAIT;
`ifdef KEY_DEBOUNCER_REPEAT_EN
                rcnt <= rcnt_nx;
`endif
            end
        end
        // filter transitions; a single opposite sample in a wait state aborts the window
        always_comb begin
            state_nx = state;
            cnt_nx = cnt;
            press_nx = 1'b0;
            rel_nx = 1'b0;
            case (state)
                IDLE: begin
                    if (!s2) begin
                        state_nx = PRESS_WAIT;
                        cnt_nx = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s2) state_nx = IDLE;
                    else if (done) begin
                        state_nx = HELD;
                        press_nx = 1'b1;
                    end else cnt_nx = cnt + 1'b1;
                end
                HELD: begin
                    if (s2) begin
                        state_nx = RELEASE_WAIT;
                        cnt_nx = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!s2) state_nx = HELD;
                    else if (done) begin
                        state_nx = IDLE;
                        rel_nx = 1'b1;
                    end else cnt_nx = cnt + 1'b1;
                end
                default: state_nx = IDLE;
            endcase
`ifdef KEY_DEBOUNCER_REPEAT_EN
            // repeat timer runs while pressed (including release bounces) and is re-armed only by a fresh press
            rcnt_nx = rcnt;
            if (state == PRESS_WAIT && state_nx == HELD) rcnt_nx = '0;
            else if (state_nx == IDLE) rcnt_nx = '0;
            else if (state == HELD || state == RELEASE_WAIT) begin
                if (rcnt == RW'(REPEAT_DELAY + REPEAT_PERIOD - 1)) begin
                    rcnt_nx = RW'(REPEAT_DELAY);
                    press_nx = 1'b1;
                end else begin
                    rcnt_nx = rcnt + 1'b1;
                    press_nx = rcnt == RW'(REPEAT_DELAY - 1);
                end
            end
`endif
        end
    end
endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: directed scenarios plus random keys against a run-length reference model
module tb_key_debouncer;
    localparam int N = 3;
    localparam int D = 4;
    localparam int RD = 10;
    localparam int RP = 3;
`ifdef KEY_DEBOUNCER_REPEAT_EN
    localparam int HOLD_PULSES = 8;
`else
    localparam int HOLD_PULSES = 1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int edge_n = 0;
    logic [N-1:0] m_db = '1, m_pr = '0, m_rl = '0, ms1 = '1, ms2 = '1;
    int run [N];
    int t [N];
    key_debouncer_if #(.N_KEYS(N)) bus ();
    key_debouncer #(
        .N_KEYS(N),
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask
    task automatic wait_edge(input int n);
        while (edge_n < n) @(negedge clk);
    endtask
    // reference: a change is accepted once the synchronised key has disagreed with the level for D+1 edges
    always @(posedge clk) begin
        edge_n++;
        for (int c = 0; c < N; c++) begin
            m_pr[c] = 1'b0;
            m_rl[c] = 1'b0;
            if (rst) begin
                m_db[c] = 1'b1;
                ms1[c] = 1'b1;
                ms2[c] = 1'b1;
                run[c] = 0;
                t[c] = 0;
            end else begin
                run[c] = (ms2[c] == m_db[c]) ? 0 : run[c] + 1;
                if (run[c] == D + 1) begin
                    m_db[c] = ~m_db[c];
                    run[c] = 0;
                    t[c] = 0;
                    if (m_db[c]) m_rl[c] = 1'b1;
                    else m_pr[c] = 1'b1;
                end else if (!m_db[c]) begin
                    t[c]++;
`ifdef KEY_DEBOUNCER_REPEAT_EN
                    if (t[c] >= RD && (t[c] - RD) % RP == 0) m_pr[c] = 1'b1;
`endif
                end
                ms2[c] = ms1[c];
                ms1[c] = bus.key[c];
            end
        end
    end
    // compare every cycle away from the active edge
    always @(negedge clk) begin
        check("key_db", 32'(bus.key_db), 32'(m_db));
        check("press", 32'(bus.press), 32'(m_pr));
        check("release", 32'(bus.rel), 32'(m_rl));
    end
    initial begin
        int first, cnt;
        logic seen;
        logic [3:0] bnc;
        logic db_at;
        bus.key = '1;
        wait_edge(3);
        rst = 1'b0;
        check("rst_db", 32'(bus.key_db), 32'h7);
        check("rst_press", 32'(bus.press), 32'h0);
        check("rst_rel", 32'(bus.rel), 32'h0);
        wait_edge(9);
        bus.key[0] = 1'b0;
        wait_edge(15);
        check("clean_early", 32'({bus.key_db[0], bus.press[0]}), 32'h2);
        wait_edge(16);
        check("clean_db", 32'(bus.key_db), 32'h6);
        check("clean_press", 32'(bus.press), 32'h1);
        wait_edge(17);
        check("clean_drop", 32'(bus.press), 32'h0);
        wait_edge(20);
        seen = 1'b0;
        bnc = 4'b0000;
        for (int n = 0; n < 18; n++) begin
            bus.key[1] = (n == 2 || n >= 5);
            @(negedge clk);
            seen = seen | bus.press[1] | ~bus.key_db[1];
        end
        check("bounce_seen", 32'(seen), 32'h0);
        bnc = 4'b1011;
        for (int n = 0; n < 3; n++) begin
            bus.key[0] = bnc[n];
            @(negedge clk);
        end
        bus.key[0] = 1'b1;
        first = 0;
        cnt = 0;
        db_at = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.rel[0]) begin
                cnt++;
                if (first == 0) begin
                    first = n;
                    db_at = bus.key_db[0];
                end
            end
        end
        check("rel_latency", 32'(first), 32'd7);
        check("rel_count", 32'(cnt), 32'd1);
        check("rel_db", 32'(db_at), 32'h1);
        bus.key[2] = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.press[2]) cnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        first = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (bus.press[2]) begin
                cnt++;
                if (first == 0) first = n;
            end
        end
        check("rst_mid_latency", 32'(first), 32'd7);
        check("rst_mid_count", 32'(cnt), 32'd1);
        bus.key = '1;
        repeat (12) @(negedge clk);
        bus.key = '0;
        repeat (7) @(negedge clk);
        check("all_press", 32'(bus.press), 32'h7);
        check("all_db", 32'(bus.key_db), 32'h0);
        @(negedge clk);
        check("all_drop", 32'(bus.press), 32'h0);
        bus.key = '1;
        repeat (12) @(negedge clk);
        bus.key[0] = 1'b0;
        cnt = 0;
        for (int n = 0; n < 45; n++) begin
            if (n == 30) bus.key[0] = 1'b1;
            @(negedge clk);
            if (bus.press[0]) cnt++;
        end
        check("hold_pulses", 32'(cnt), 32'(HOLD_PULSES));
        for (int n = 0; n < 1500; n++) begin
            int odds;
            odds = ((n / 100) % 2 == 0) ? 3 : 20;
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, odds - 1) == 0) bus.key[c] = ~bus.key[c];
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
